// File: rtl/matmul_engine.sv
// M x K by K x N matrix multiply controller with one pipelined MAC.
// Reads A/B row-major from sync memories, writes saturated R with backpressure.
module matmul_engine #(
  parameter int DW     = 8,
  parameter int M_ROWS = 2,
  parameter int K_DIM  = 2,
  parameter int N_COLS = 2,
  parameter int OUT_W  = 16,
  parameter int AW     = 8,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             a_rd_en,
  output logic [AW-1:0]    a_rd_addr,
  input  logic [DW-1:0]    a_rd_data,
  output logic             b_rd_en,
  output logic [AW-1:0]    b_rd_addr,
  input  logic [DW-1:0]    b_rd_data,
  output logic             r_wr_en,
  output logic [AW-1:0]    r_wr_addr,
  output logic [OUT_W-1:0] r_wr_data,
  input  logic             r_wr_ready
);

  localparam int KB    = $clog2(K_DIM);
  localparam int ACC_W = 2*DW + KB + 1;
  localparam int PW    = 2*DW + 2;
  localparam int EW    = (ACC_W > PW) ? ACC_W : PW;

  localparam logic [AW-1:0] KD    = AW'(K_DIM);
  localparam logic [AW-1:0] ND    = AW'(N_COLS);
  localparam logic [AW-1:0] K_END = AW'(K_DIM - 1);
  localparam logic [AW-1:0] N_END = AW'(N_COLS - 1);
  localparam logic [AW-1:0] M_END = AW'(M_ROWS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]              state;
  logic [AW-1:0]           i;
  logic [AW-1:0]           j;
  logic [AW-1:0]           k;
  logic signed [ACC_W-1:0] acc;
  logic                    mac_v;
  logic signed [DW:0]      a_x;
  logic signed [DW:0]      b_x;
  logic signed [PW-1:0]    prod;
  logic signed [EW-1:0]    sum;
  logic [OUT_W-1:0]        sat;
  logic                    last_k;
  logic                    last_j;
  logic                    last_i;

  always_comb begin
    a_x = (SIGNED != 0) ? {a_rd_data[DW-1], a_rd_data}
                        : {1'b0, a_rd_data};
    b_x = (SIGNED != 0) ? {b_rd_data[DW-1], b_rd_data}
                        : {1'b0, b_rd_data};
    prod = a_x * b_x;
    sum  = EW'(acc) + EW'(prod);
  end

  assign last_k = (k == K_END);
  assign last_j = (j == N_END);
  assign last_i = (i == M_END);

  // Clamp only when the accumulator is wider than the result word
  if (ACC_W > OUT_W) begin : g_sat
    if (SIGNED != 0) begin : g_s
      localparam int HW = ACC_W - OUT_W + 1;
      always_comb begin
        if (acc[ACC_W-1:OUT_W-1] == {HW{acc[ACC_W-1]}})
          sat = acc[OUT_W-1:0];
        else
          sat = {acc[ACC_W-1], {(OUT_W-1){~acc[ACC_W-1]}}};
      end
    end else begin : g_u
      always_comb begin
        if (|acc[ACC_W-1:OUT_W])
          sat = '1;
        else
          sat = acc[OUT_W-1:0];
      end
    end
  end else begin : g_pass
    assign sat = OUT_W'(acc);
  end

  assign busy      = (state == S_RUN) || (state == S_DRAIN) ||
                     (state == S_WRITE);
  assign done      = (state == S_DONE);
  assign a_rd_en   = (state == S_RUN);
  assign b_rd_en   = (state == S_RUN);
  assign a_rd_addr = i * KD + k;
  assign b_rd_addr = k * ND + j;
  assign r_wr_en   = (state == S_WRITE);
  assign r_wr_addr = i * ND + j;
  assign r_wr_data = sat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      acc   <= '0;
      mac_v <= 1'b0;
    end else begin
      // Read data lands one cycle after the strobe; add it then
      mac_v <= (state == S_RUN);
      if (mac_v)
        acc <= sum[ACC_W-1:0];
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
          end
        end
        S_RUN: begin
          if (last_k)
            state <= S_DRAIN;
          else
            k <= k + 1'b1;
        end
        S_DRAIN: state <= S_WRITE;
        S_WRITE: begin
          if (r_wr_ready) begin
            acc <= '0;
            k   <= '0;
            if (last_j) begin
              j <= '0;
              i <= last_i ? '0 : i + 1'b1;
            end else begin
              j <= j + 1'b1;
            end
            state <= (last_i && last_j) ? S_DONE : S_RUN;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_engine.sv
// Directed bench for matmul_engine: 2x2x2 product, saturation,
// signed mode, backpressure, start while busy and reset abort.
module tb_matmul_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  logic one = 1'b1;

  // u0: default 2x2x2 unsigned
  logic        s0, by0, dn0, ae0, be0, we0;
  logic        rd0;
  logic [7:0]  aa0, ba0, wa0, ad0, bd0;
  logic [15:0] wd0;
  logic [7:0]  ma0 [4];
  logic [7:0]  mb0 [4];
  logic [7:0]  la0 [32];
  logic [15:0] ld0 [32];
  int wn0 = 0, nd0 = 0, oob0 = 0;

  matmul_engine u0 (
    .clk(clk), .rst(rst), .start(s0), .busy(by0), .done(dn0),
    .a_rd_en(ae0), .a_rd_addr(aa0), .a_rd_data(ad0),
    .b_rd_en(be0), .b_rd_addr(ba0), .b_rd_data(bd0),
    .r_wr_en(we0), .r_wr_addr(wa0), .r_wr_data(wd0),
    .r_wr_ready(rd0)
  );

  always @(posedge clk) begin
    if (ae0) ad0 <= ma0[aa0[1:0]];
    if (be0) bd0 <= mb0[ba0[1:0]];
    if (we0 && rd0) begin
      la0[wn0 % 32] <= wa0;
      ld0[wn0 % 32] <= wd0;
      wn0 <= wn0 + 1;
    end
    if (dn0) nd0 <= nd0 + 1;
    if ((ae0 && aa0 > 3) || (be0 && ba0 > 3) || (we0 && wa0 > 3))
      oob0 <= oob0 + 1;
  end

  // u1: 1x10 by 10x2, all 255, saturating
  logic        s1, by1, dn1, ae1, be1, we1;
  logic [7:0]  aa1, ba1, wa1, ad1, bd1;
  logic [15:0] wd1;
  logic [7:0]  la1 [4];
  logic [15:0] ld1 [4];
  int wn1 = 0, oob1 = 0;

  matmul_engine #(.DW(8), .M_ROWS(1), .K_DIM(10), .N_COLS(2),
                  .OUT_W(16), .AW(8), .SIGNED(0)) u1 (
    .clk(clk), .rst(rst), .start(s1), .busy(by1), .done(dn1),
    .a_rd_en(ae1), .a_rd_addr(aa1), .a_rd_data(ad1),
    .b_rd_en(be1), .b_rd_addr(ba1), .b_rd_data(bd1),
    .r_wr_en(we1), .r_wr_addr(wa1), .r_wr_data(wd1),
    .r_wr_ready(one)
  );

  always @(posedge clk) begin
    if (ae1) ad1 <= 8'hFF;
    if (be1) bd1 <= 8'hFF;
    if (we1) begin
      la1[wn1 % 4] <= wa1;
      ld1[wn1 % 4] <= wd1;
      wn1 <= wn1 + 1;
    end
    if ((ae1 && aa1 > 9) || (be1 && ba1 > 19) || (we1 && wa1 > 1))
      oob1 <= oob1 + 1;
  end

  // u2/u3: signed 1x1x1, OUT_W 16 and 8
  logic        s23, by2, dn2, ae2, be2, we2;
  logic        by3, dn3, ae3, be3, we3;
  logic [7:0]  aa2, ba2, wa2, ad2, bd2, a2v, b2v;
  logic [7:0]  aa3, ba3, wa3, ad3, bd3, a3v, b3v;
  logic [15:0] wd2, lw2;
  logic [7:0]  wd3, lw3;
  int wn2 = 0, wn3 = 0;

  matmul_engine #(.DW(8), .M_ROWS(1), .K_DIM(1), .N_COLS(1),
                  .OUT_W(16), .AW(8), .SIGNED(1)) u2 (
    .clk(clk), .rst(rst), .start(s23), .busy(by2), .done(dn2),
    .a_rd_en(ae2), .a_rd_addr(aa2), .a_rd_data(ad2),
    .b_rd_en(be2), .b_rd_addr(ba2), .b_rd_data(bd2),
    .r_wr_en(we2), .r_wr_addr(wa2), .r_wr_data(wd2),
    .r_wr_ready(one)
  );

  matmul_engine #(.DW(8), .M_ROWS(1), .K_DIM(1), .N_COLS(1),
                  .OUT_W(8), .AW(8), .SIGNED(1)) u3 (
    .clk(clk), .rst(rst), .start(s23), .busy(by3), .done(dn3),
    .a_rd_en(ae3), .a_rd_addr(aa3), .a_rd_data(ad3),
    .b_rd_en(be3), .b_rd_addr(ba3), .b_rd_data(bd3),
    .r_wr_en(we3), .r_wr_addr(wa3), .r_wr_data(wd3),
    .r_wr_ready(one)
  );

  always @(posedge clk) begin
    if (ae2) ad2 <= a2v;
    if (be2) bd2 <= b2v;
    if (ae3) ad3 <= a3v;
    if (be3) bd3 <= b3v;
    if (we2) begin
      lw2 <= wd2;
      wn2 <= wn2 + 1;
    end
    if (we3) begin
      lw3 <= wd3;
      wn3 <= wn3 + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one u0 job; cyc is the cycle index at which done is seen
  task automatic run0(input bit bp, input bit poke,
                      output int cyc, output int stab);
    int hold;
    logic [7:0]  ca;
    logic [15:0] cd;
    hold = 0;
    stab = 0;
    ca = '0;
    cd = '0;
    rd0 = bp ? 1'b0 : 1'b1;
    s0 = 1'b1;
    tick();
    s0 = 1'b0;
    cyc = 1;
    while (!dn0 && cyc < 400) begin
      s0 = (poke && (cyc == 2 || cyc == 9)) ? 1'b1 : 1'b0;
      tick();
      cyc++;
      if (bp) begin
        if (we0) begin
          if (hold == 0) begin
            ca = wa0;
            cd = wd0;
          end else if (wa0 !== ca || wd0 !== cd) begin
            stab++;
          end
          hold++;
          rd0 = (hold >= 6);
        end else begin
          hold = 0;
          rd0 = 1'b0;
        end
      end
    end
    s0 = 1'b0;
    rd0 = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if ({by0, dn0, ae0, aa0, be0, ba0, we0, wa0, wd0} !== '0) begin
      errs++;
      $display("FAIL reset_u0: got %h want 0",
               {by0, dn0, ae0, aa0, be0, ba0, we0, wa0, wd0});
    end
    checks++;
    if ({by2, dn2, ae2, aa2, be2, ba2, we2, wa2, wd2,
         by3, dn3, we3, wd3} !== '0) begin
      errs++;
      $display("FAIL reset_u23: got nonzero outputs want 0");
    end
    rst = 1'b1;
    tick();
    checks++;
    if (by0 !== 1'b0 || dn0 !== 1'b0) begin
      errs++;
      $display("FAIL idle_after_reset: busy=%b done=%b want 0 0",
               by0, dn0);
    end
  endtask

  task automatic test_basic;
    int b, n, cyc, st;
    logic [15:0] ex [4];
    ex = '{16'd19, 16'd22, 16'd43, 16'd50};
    b = wn0;
    n = nd0;
    run0(1'b0, 1'b0, cyc, st);
    checks++;
    if (cyc !== 17) begin
      errs++;
      $display("FAIL t1_latency: got %0d want 17", cyc);
    end
    checks++;
    if (by0 !== 1'b0) begin
      errs++;
      $display("FAIL t1_busy_at_done: got %b want 0", by0);
    end
    tick();
    checks++;
    if (dn0 !== 1'b0 || nd0 - n !== 1) begin
      errs++;
      $display("FAIL t1_done_pulse: done=%b pulses=%0d want 0 1",
               dn0, nd0 - n);
    end
    checks++;
    if (wn0 - b !== 4) begin
      errs++;
      $display("FAIL t1_nwrites: got %0d want 4", wn0 - b);
    end
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (la0[(b+e)%32] !== 8'(e) || ld0[(b+e)%32] !== ex[e]) begin
        errs++;
        $display("FAIL t1_r%0d: got @%0d=%0d want @%0d=%0d", e,
                 la0[(b+e)%32], ld0[(b+e)%32], e, ex[e]);
      end
    end
  endtask

  task automatic test_saturate;
    int cyc;
    s1 = 1'b1;
    tick();
    s1 = 1'b0;
    cyc = 1;
    while (!dn1 && cyc < 200) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 25) begin
      errs++;
      $display("FAIL t2_latency: got %0d want 25", cyc);
    end
    tick();
    checks++;
    if (wn1 !== 2) begin
      errs++;
      $display("FAIL t2_nwrites: got %0d want 2", wn1);
    end
    for (int e = 0; e < 2; e++) begin
      checks++;
      if (la1[e] !== 8'(e) || ld1[e] !== 16'hFFFF) begin
        errs++;
        $display("FAIL t2_r%0d: got @%0d=%0d want @%0d=65535",
                 e, la1[e], ld1[e], e);
      end
    end
    checks++;
    if (oob1 !== 0) begin
      errs++;
      $display("FAIL t2_bounds: got %0d out-of-range want 0", oob1);
    end
  endtask

  task automatic run23(input logic [7:0] a2, input logic [7:0] b2,
                       input logic [7:0] a3, input logic [7:0] b3,
                       output int cyc);
    a2v = a2;
    b2v = b2;
    a3v = a3;
    b3v = b3;
    s23 = 1'b1;
    tick();
    s23 = 1'b0;
    cyc = 1;
    while (!dn2 && cyc < 50) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_signed;
    int cyc;
    run23(8'h80, 8'h7F, 8'h80, 8'h80, cyc);
    checks++;
    if (cyc !== 4 || dn3 !== 1'b1) begin
      errs++;
      $display("FAIL t3_latency: got %0d done3=%b want 4 1", cyc, dn3);
    end
    checks++;
    if (lw2 !== 16'hC080) begin
      errs++;
      $display("FAIL t3_neg_product: got %h want c080", lw2);
    end
    checks++;
    if (lw3 !== 8'h7F) begin
      errs++;
      $display("FAIL t3_clamp_pos: got %h want 7f", lw3);
    end
    tick();
    run23(8'h05, 8'hFD, 8'h80, 8'h7F, cyc);
    checks++;
    if (lw2 !== 16'hFFF1) begin
      errs++;
      $display("FAIL t3_small_neg: got %h want fff1", lw2);
    end
    checks++;
    if (lw3 !== 8'h80) begin
      errs++;
      $display("FAIL t3_clamp_neg: got %h want 80", lw3);
    end
    checks++;
    if (wn2 !== 2 || wn3 !== 2) begin
      errs++;
      $display("FAIL t3_nwrites: got %0d %0d want 2 2", wn2, wn3);
    end
    tick();
  endtask

  task automatic test_backpressure;
    int b, cyc, st;
    logic [15:0] ex [4];
    ex = '{16'd19, 16'd22, 16'd43, 16'd50};
    b = wn0;
    run0(1'b1, 1'b0, cyc, st);
    checks++;
    if (cyc !== 37) begin
      errs++;
      $display("FAIL t4_latency: got %0d want 37", cyc);
    end
    checks++;
    if (st !== 0) begin
      errs++;
      $display("FAIL t4_stable: got %0d changes want 0", st);
    end
    tick();
    checks++;
    if (wn0 - b !== 4) begin
      errs++;
      $display("FAIL t4_nwrites: got %0d want 4", wn0 - b);
    end
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (la0[(b+e)%32] !== 8'(e) || ld0[(b+e)%32] !== ex[e]) begin
        errs++;
        $display("FAIL t4_r%0d: got @%0d=%0d want @%0d=%0d", e,
                 la0[(b+e)%32], ld0[(b+e)%32], e, ex[e]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int b, n, cyc, st;
    b = wn0;
    n = nd0;
    run0(1'b0, 1'b1, cyc, st);
    checks++;
    if (cyc !== 17) begin
      errs++;
      $display("FAIL t5_latency: got %0d want 17", cyc);
    end
    s0 = 1'b1;
    tick();
    s0 = 1'b0;
    tick();
    checks++;
    if (by0 !== 1'b0) begin
      errs++;
      $display("FAIL t5_start_in_done: busy=%b want 0", by0);
    end
    checks++;
    if (wn0 - b !== 4 || nd0 - n !== 1) begin
      errs++;
      $display("FAIL t5_counts: writes=%0d dones=%0d want 4 1",
               wn0 - b, nd0 - n);
    end
    checks++;
    if (ld0[(b+3)%32] !== 16'd50 || ld0[b%32] !== 16'd19) begin
      errs++;
      $display("FAIL t5_data: got %0d %0d want 19 50",
               ld0[b%32], ld0[(b+3)%32]);
    end
  endtask

  task automatic test_abort;
    int b, n;
    b = wn0;
    n = nd0;
    rd0 = 1'b1;
    s0 = 1'b1;
    tick();
    s0 = 1'b0;
    checks++;
    if (by0 !== 1'b1) begin
      errs++;
      $display("FAIL t6_busy: got %b want 1", by0);
    end
    repeat (5) tick();
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({by0, dn0, ae0, aa0, be0, ba0, we0, wa0, wd0} !== '0) begin
      errs++;
      $display("FAIL t6_abort_outputs: got %h want 0",
               {by0, dn0, ae0, aa0, be0, ba0, we0, wa0, wd0});
    end
    repeat (3) tick();
    checks++;
    if (wn0 - b !== 1 || nd0 - n !== 0) begin
      errs++;
      $display("FAIL t6_abort_counts: writes=%0d dones=%0d want 1 0",
               wn0 - b, nd0 - n);
    end
    rst = 1'b1;
    tick();
    test_basic();
    checks++;
    if (oob0 !== 0) begin
      errs++;
      $display("FAIL u0_bounds: got %0d out-of-range want 0", oob0);
    end
  endtask

  initial begin
    s0 = 1'b0;
    s1 = 1'b0;
    s23 = 1'b0;
    rd0 = 1'b1;
    a2v = '0;
    b2v = '0;
    a3v = '0;
    b3v = '0;
    ma0 = '{8'd1, 8'd2, 8'd3, 8'd4};
    mb0 = '{8'd5, 8'd6, 8'd7, 8'd8};
    test_reset();
    test_basic();
    test_saturate();
    test_signed();
    test_backpressure();
    test_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
